// File: rtl/cnt_mon_pkg.sv
// Shared definitions for the counter wrap monitor.
//   state_t : FSM state encoding (INIT=0, TRACK=1, ERROR=2)
//   CNT_MAX : terminal value of the upstream 4-bit counter
package cnt_mon_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'd15;

endpackage : cnt_mon_pkg

// File: rtl/inc4.sv
// 4-bit incrementer: sum = a + 1, cout is the carry out of bit 3.
//   a    : 4-bit operand
//   sum  : 4-bit result (wraps 15 -> 0)
//   cout : high exactly when a == 15
module inc4 (
  input  logic [3:0] a,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + 5'd1;

endmodule : inc4

// File: rtl/cnt_wrap_monitor.sv
// Watches a free-running 4-bit counter, counts its 15->0 wraps and flags the
// first break in the +1 sequence.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   en         : sample enable; low freezes everything, wrap_pulse reads 0
//   clr        : synchronous clear back to the post-reset state (beats en)
//   cnt_in     : upstream counter value
//   wrap_pulse : one-cycle pulse per observed 15->0 step
//   epoch      : wrap count modulo 2^EPOCH_W
//   epoch_ovf  : sticky, epoch rolled over from all-ones
//   err        : sticky, a sequence violation was seen
//   err_exp    : value expected at the first violation
//   err_got    : value received at the first violation
module cnt_wrap_monitor
  import cnt_mon_pkg::*;
#(
  parameter int EPOCH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [3:0]         cnt_in,
  output logic               wrap_pulse,
  output logic [EPOCH_W-1:0] epoch,
  output logic               epoch_ovf,
  output logic               err,
  output logic [3:0]         err_exp,
  output logic [3:0]         err_got
);

  state_t               state_q;
  state_t               state_d;
  logic [3:0]           prev_q;
  logic [3:0]           prev_d;
  logic                 wrap_pulse_d;
  logic [EPOCH_W-1:0]   epoch_d;
  logic                 epoch_ovf_d;
  logic                 err_d;
  logic [3:0]           err_exp_d;
  logic [3:0]           err_got_d;

  logic [3:0]           exp_val;
  logic                 exp_carry;
  logic [EPOCH_W:0]     epoch_inc;

  inc4 u_inc4 (
    .a    (prev_q),
    .sum  (exp_val),
    .cout (exp_carry)
  );

  // Top bit of epoch_inc is the rollover from all-ones to zero.
  assign epoch_inc = {1'b0, epoch} + {{EPOCH_W{1'b0}}, 1'b1};

  // The incrementer carry and the terminal-count compare must agree; the
  // wrap decision below relies on the explicit compare.
  always_comb begin
    if (rst) begin
      assert (exp_carry == (prev_q == CNT_MAX));
    end
  end

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    wrap_pulse_d = 1'b0;
    epoch_d      = epoch;
    epoch_ovf_d  = epoch_ovf;
    err_d        = err;
    err_exp_d    = err_exp;
    err_got_d    = err_got;

    if (clr) begin
      state_d     = ST_INIT;
      prev_d      = 4'd0;
      epoch_d     = '0;
      epoch_ovf_d = 1'b0;
      err_d       = 1'b0;
      err_exp_d   = 4'd0;
      err_got_d   = 4'd0;
    end else if (en) begin
      prev_d = cnt_in;
      case (state_q)
        ST_INIT: begin
          state_d = ST_TRACK;
        end
        ST_TRACK: begin
          if (cnt_in == exp_val) begin
            if (prev_q == CNT_MAX) begin
              wrap_pulse_d = 1'b1;
              epoch_d      = epoch_inc[EPOCH_W-1:0];
              if (epoch_inc[EPOCH_W]) begin
                epoch_ovf_d = 1'b1;
              end
            end
          end else begin
            state_d   = ST_ERROR;
            err_d     = 1'b1;
            err_exp_d = exp_val;
            err_got_d = cnt_in;
          end
        end
        ST_ERROR: begin
          // Keep following the counter, but report nothing further.
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      prev_q     <= 4'd0;
      wrap_pulse <= 1'b0;
      epoch      <= '0;
      epoch_ovf  <= 1'b0;
      err        <= 1'b0;
      err_exp    <= 4'd0;
      err_got    <= 4'd0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      wrap_pulse <= wrap_pulse_d;
      epoch      <= epoch_d;
      epoch_ovf  <= epoch_ovf_d;
      err        <= err_d;
      err_exp    <= err_exp_d;
      err_got    <= err_got_d;
    end
  end

endmodule : cnt_wrap_monitor
